// File: rtl/dmac_axi_mem_if.sv
// AXI3-style bus bundle between the DMA engine (master) and dmac_axi_mem (slave).
// Carries the AW/W/B write channels and the AR/R read channels, 32-bit data,
// 4-bit burst length (beats-1).
interface dmac_axi_mem_if;
  // Write address channel
  logic [31:0] awaddr;
  logic [3:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic        awvalid;
  logic        awready;
  // Write data channel
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;
  // Write response channel
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  // Read address channel
  logic [31:0] araddr;
  logic [3:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid;
  logic        arready;
  // Read data channel
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;

  modport master (
    output awaddr, awlen, awsize, awburst, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bresp, bvalid,
    output bready,
    output araddr, arlen, arsize, arburst, arvalid,
    input  arready,
    input  rdata, rresp, rlast, rvalid,
    output rready
  );

  modport slave (
    input  awaddr, awlen, awsize, awburst, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bresp, bvalid,
    input  bready,
    input  araddr, arlen, arsize, arburst, arvalid,
    output arready,
    output rdata, rresp, rlast, rvalid,
    input  rready
  );
endinterface

// File: rtl/dmac_axi_mem.sv
// Slave memory terminating the DMA engine's AXI3 read and write channels.
// Serves INCR bursts of 1..16 32-bit beats out of a 2^ADDR_WIDTH word array and
// returns write responses through a 4-entry queue with a programmable delay.
// Ports:
//   clk    - clock, all state on the rising edge
//   rst_n  - asynchronous active-low reset
//   axi    - slave side of dmac_axi_mem_if (AW/W/B and AR/R channels)
module dmac_axi_mem #(
  parameter int unsigned ADDR_WIDTH    = 10,
  parameter int unsigned BRESP_LATENCY = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  dmac_axi_mem_if.slave   axi
);

  localparam int unsigned Depth      = 2 ** ADDR_WIDTH;
  localparam logic [1:0]  RespOkay   = 2'b00;
  localparam logic [1:0]  RespSlverr = 2'b10;
  localparam logic [3:0]  BLat       = 4'(BRESP_LATENCY);

  typedef enum logic {StRIdle, StRData} r_state_e;
  typedef enum logic {StWIdle, StWData} w_state_e;

  // Word storage; deliberately not reset.
  logic [31:0] mem_q [Depth];

  // Read channel state
  r_state_e              r_state_q, r_state_d;
  logic [ADDR_WIDTH-1:0] r_idx_q, r_idx_d;
  logic [3:0]            r_cnt_q, r_cnt_d;
  logic [1:0]            r_resp_q, r_resp_d;

  // Write channel state
  w_state_e              w_state_q, w_state_d;
  logic [ADDR_WIDTH-1:0] w_idx_q, w_idx_d;
  logic [3:0]            w_cnt_q, w_cnt_d;
  logic [1:0]            w_resp_q, w_resp_d;

  // B queue and outstanding-write accounting
  logic [3:0][1:0] bq_q, bq_d;
  logic [1:0]      b_rd_q, b_rd_d;
  logic [1:0]      b_wr_q, b_wr_d;
  logic [2:0]      b_cnt_q, b_cnt_d;
  logic [3:0]      b_dly_q, b_dly_d;
  logic [2:0]      pending_q, pending_d;

  logic        mem_we;
  logic        b_push;
  logic [1:0]  b_push_resp;
  logic        b_pop;
  logic        aw_hs;

  // Address bits outside the word index are ignored by design.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{axi.awaddr[31:ADDR_WIDTH+2], axi.awaddr[1:0],
                              axi.araddr[31:ADDR_WIDTH+2], axi.araddr[1:0]};

  // ---------------------------------------------------------------------------
  // Read FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    r_state_d   = r_state_q;
    r_idx_d     = r_idx_q;
    r_cnt_d     = r_cnt_q;
    r_resp_d    = r_resp_q;
    axi.arready = 1'b0;
    axi.rvalid  = 1'b0;
    axi.rlast   = 1'b0;
    axi.rresp   = RespOkay;
    unique case (r_state_q)
      StRIdle: begin
        axi.arready = 1'b1;
        if (axi.arvalid) begin
          r_idx_d   = axi.araddr[ADDR_WIDTH+1:2];
          r_cnt_d   = axi.arlen;
          r_resp_d  = (axi.arsize == 3'b010 && axi.arburst == 2'b01) ? RespOkay : RespSlverr;
          r_state_d = StRData;
        end
      end
      StRData: begin
        axi.rvalid = 1'b1;
        axi.rlast  = (r_cnt_q == 4'd0);
        axi.rresp  = r_resp_q;
        if (axi.rready) begin
          r_idx_d = r_idx_q + 1'b1;
          r_cnt_d = r_cnt_q - 4'd1;
          if (r_cnt_q == 4'd0) r_state_d = StRIdle;
        end
      end
    endcase
  end

  // Combinational read: a same-cycle write to this word is seen next cycle.
  assign axi.rdata = mem_q[r_idx_q];

  // ---------------------------------------------------------------------------
  // Write FSM
  // ---------------------------------------------------------------------------
  assign aw_hs = axi.awvalid && axi.awready;

  always_comb begin
    w_state_d   = w_state_q;
    w_idx_d     = w_idx_q;
    w_cnt_d     = w_cnt_q;
    w_resp_d    = w_resp_q;
    axi.awready = 1'b0;
    axi.wready  = 1'b0;
    mem_we      = 1'b0;
    b_push      = 1'b0;
    b_push_resp = w_resp_q;
    unique case (w_state_q)
      StWIdle: begin
        axi.awready = (pending_q < 3'd4);
        if (axi.awvalid && axi.awready) begin
          w_idx_d   = axi.awaddr[ADDR_WIDTH+1:2];
          w_cnt_d   = axi.awlen;
          w_resp_d  = (axi.awsize == 3'b010 && axi.awburst == 2'b01) ? RespOkay : RespSlverr;
          w_state_d = StWData;
        end
      end
      StWData: begin
        axi.wready = 1'b1;
        if (axi.wvalid) begin
          mem_we  = 1'b1;
          w_idx_d = w_idx_q + 1'b1;
          w_cnt_d = w_cnt_q - 4'd1;
          // Beat count, not wlast, terminates the burst; a disagreement poisons it.
          if (axi.wlast != (w_cnt_q == 4'd0)) w_resp_d = RespSlverr;
          if (w_cnt_q == 4'd0) begin
            b_push      = 1'b1;
            b_push_resp = w_resp_d;
            w_state_d   = StWIdle;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (axi.wstrb[b]) mem_q[w_idx_q][8*b +: 8] <= axi.wdata[8*b +: 8];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // B response queue
  // ---------------------------------------------------------------------------
  assign axi.bvalid = (b_cnt_q != 3'd0) && (b_dly_q == 4'd0);
  assign axi.bresp  = (b_cnt_q != 3'd0) ? bq_q[b_rd_q] : RespOkay;
  assign b_pop      = axi.bvalid && axi.bready;

  always_comb begin
    bq_d    = bq_q;
    b_rd_d  = b_rd_q;
    b_wr_d  = b_wr_q;
    b_cnt_d = b_cnt_q + {2'b00, b_push} - {2'b00, b_pop};
    b_dly_d = b_dly_q;
    if (b_push) begin
      bq_d[b_wr_q] = b_push_resp;
      b_wr_d       = b_wr_q + 2'd1;
    end
    if (b_pop) b_rd_d = b_rd_q + 2'd1;
    // Reload the delay whenever a new entry becomes head.
    if ((b_push && b_cnt_q == 3'd0) || (b_pop && b_cnt_d != 3'd0)) begin
      b_dly_d = BLat;
    end else if (b_dly_q != 4'd0) begin
      b_dly_d = b_dly_q - 4'd1;
    end
    pending_d = pending_q + {2'b00, aw_hs} - {2'b00, b_pop};
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state_q <= StRIdle;
      r_idx_q   <= '0;
      r_cnt_q   <= '0;
      r_resp_q  <= RespOkay;
      w_state_q <= StWIdle;
      w_idx_q   <= '0;
      w_cnt_q   <= '0;
      w_resp_q  <= RespOkay;
      bq_q      <= '0;
      b_rd_q    <= '0;
      b_wr_q    <= '0;
      b_cnt_q   <= '0;
      b_dly_q   <= '0;
      pending_q <= '0;
    end else begin
      r_state_q <= r_state_d;
      r_idx_q   <= r_idx_d;
      r_cnt_q   <= r_cnt_d;
      r_resp_q  <= r_resp_d;
      w_state_q <= w_state_d;
      w_idx_q   <= w_idx_d;
      w_cnt_q   <= w_cnt_d;
      w_resp_q  <= w_resp_d;
      bq_q      <= bq_d;
      b_rd_q    <= b_rd_d;
      b_wr_q    <= b_wr_d;
      b_cnt_q   <= b_cnt_d;
      b_dly_q   <= b_dly_d;
      pending_q <= pending_d;
    end
  end

endmodule

// File: tb/tb_dmac_axi_mem.sv
// Self-checking bench for dmac_axi_mem: table of single-beat write/readback
// vectors plus directed burst, back-pressure, illegal-burst and reset sequences.
module tb_dmac_axi_mem;

  localparam int Lat = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dmac_axi_mem_if axi ();

  dmac_axi_mem #(
    .ADDR_WIDTH   (10),
    .BRESP_LATENCY(Lat)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .axi  (axi)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_pass = 0;

  logic [31:0] wbuf [16];
  logic [31:0] rbuf [16];
  logic [1:0]  rresp_buf [16];
  logic        rlast_buf [16];
  int          r_first, r_last;

  typedef struct {
    logic [31:0] waddr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] raddr;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic timeout(input string name);
    n_chk++;
    $display("FAIL %s: timed out waiting for handshake", name);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    axi.awaddr = '0; axi.awlen = '0; axi.awsize = 3'b010; axi.awburst = 2'b01; axi.awvalid = 0;
    axi.wdata = '0; axi.wstrb = '0; axi.wlast = 0; axi.wvalid = 0; axi.bready = 0;
    axi.araddr = '0; axi.arlen = '0; axi.arsize = 3'b010; axi.arburst = 2'b01; axi.arvalid = 0;
    axi.rready = 0;
  endtask

  task automatic do_aw(input logic [31:0] addr, input logic [3:0] len, input logic [2:0] size,
                       input logic [1:0] burst, output int hs);
    int i = 0;
    axi.awaddr = addr; axi.awlen = len; axi.awsize = size; axi.awburst = burst;
    axi.awvalid = 1;
    hs = -1;
    while (hs < 0 && i < 100) begin
      @(negedge clk);
      if (axi.awready) hs = cyc;
      tick();
      i++;
    end
    axi.awvalid = 0;
    if (hs < 0) timeout("aw");
  endtask

  task automatic do_w(input int nbeats, input logic [3:0] strb, input int last_pos,
                      output int first_hs, output int last_hs);
    first_hs = -1;
    last_hs  = -1;
    for (int b = 0; b < nbeats; b++) begin
      int hs = -1;
      int i  = 0;
      axi.wdata = wbuf[b]; axi.wstrb = strb; axi.wlast = (b == last_pos); axi.wvalid = 1;
      while (hs < 0 && i < 100) begin
        @(negedge clk);
        if (axi.wready) hs = cyc;
        tick();
        i++;
      end
      if (hs < 0) timeout("w");
      if (b == 0) first_hs = hs;
      last_hs = hs;
    end
    axi.wvalid = 0;
    axi.wlast  = 0;
  endtask

  task automatic wait_b(input logic [1:0] exp, input int exp_cyc, input string name);
    int seen = -1;
    int i    = 0;
    axi.bready = 1;
    while (seen < 0 && i < 100) begin
      @(negedge clk);
      if (axi.bvalid) begin
        seen = cyc;
        check({name, "_bresp"}, 32'(axi.bresp), 32'(exp));
      end
      tick();
      i++;
    end
    axi.bready = 0;
    if (seen < 0) timeout({name, "_b"});
    else if (exp_cyc >= 0) check({name, "_blat"}, seen, exp_cyc);
  endtask

  task automatic do_ar(input logic [31:0] addr, input logic [3:0] len, input logic [2:0] size,
                       input logic [1:0] burst, output int hs);
    int i = 0;
    axi.araddr = addr; axi.arlen = len; axi.arsize = size; axi.arburst = burst;
    axi.arvalid = 1;
    hs = -1;
    while (hs < 0 && i < 100) begin
      @(negedge clk);
      if (axi.arready) hs = cyc;
      tick();
      i++;
    end
    axi.arvalid = 0;
    if (hs < 0) timeout("ar");
  endtask

  task automatic collect_r(input int nbeats);
    axi.rready = 1;
    for (int b = 0; b < nbeats; b++) begin
      int hs = -1;
      int i  = 0;
      while (hs < 0 && i < 100) begin
        @(negedge clk);
        if (axi.rvalid) begin
          hs = cyc;
          rbuf[b] = axi.rdata; rresp_buf[b] = axi.rresp; rlast_buf[b] = axi.rlast;
        end
        tick();
        i++;
      end
      if (hs < 0) timeout("r");
      if (b == 0) r_first = hs;
      r_last = hs;
    end
    axi.rready = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int hs, fw, lw, nb;
    vecs[0] = '{32'h0000_0200, 32'hFFFF_FFFF, 4'hF, 32'h0000_0200, 32'hFFFF_FFFF};
    vecs[1] = '{32'h0000_0200, 32'h1234_5678, 4'h5, 32'h0000_0200, 32'hFF34_FF78};
    vecs[2] = '{32'h0000_0204, 32'hA5A5_A5A5, 4'hF, 32'h0000_0204, 32'hA5A5_A5A5};
    vecs[3] = '{32'h0000_0204, 32'h0000_0000, 4'hA, 32'h0000_0204, 32'h00A5_00A5};
    vecs[4] = '{32'h0000_1208, 32'hDEAD_BEEF, 4'hF, 32'h0000_020A, 32'hDEAD_BEEF};
    vecs[5] = '{32'h0000_0FFC, 32'hCAFE_F00D, 4'hF, 32'h0000_7FFC, 32'hCAFE_F00D};
    vecs[6] = '{32'h0000_0FFC, 32'h0000_00AB, 4'h1, 32'h0000_0FFF, 32'hCAFE_F0AB};

    idle_inputs();
    rst_n = 0;
    tick();
    @(negedge clk);
    check("rst_rvalid", 32'(axi.rvalid), 32'd0);
    check("rst_bvalid", 32'(axi.bvalid), 32'd0);
    check("rst_wready", 32'(axi.wready), 32'd0);
    check("rst_rlast", 32'(axi.rlast), 32'd0);
    check("rst_rresp", 32'(axi.rresp), 32'd0);
    check("rst_bresp", 32'(axi.bresp), 32'd0);
    check("rst_arready", 32'(axi.arready), 32'd1);
    check("rst_awready", 32'(axi.awready), 32'd1);
    tick();
    rst_n = 1;
    tick();

    // Single-beat write/readback vectors: strobes, aliasing, wrap, addr[1:0] ignored.
    for (int v = 0; v < 7; v++) begin
      wbuf[0] = vecs[v].wdata;
      do_aw(vecs[v].waddr, 4'd0, 3'b010, 2'b01, hs);
      do_w(1, vecs[v].wstrb, 0, fw, lw);
      wait_b(2'b00, -1, $sformatf("vec%0d", v));
      do_ar(vecs[v].raddr, 4'd0, 3'b010, 2'b01, hs);
      collect_r(1);
      check($sformatf("vec%0d_rdata", v), rbuf[0], vecs[v].exp);
    end

    // Preload mem[0..15] = i, then a 16-beat read.
    for (int i = 0; i < 16; i++) wbuf[i] = 32'(i);
    do_aw(32'h0, 4'd15, 3'b010, 2'b01, hs);
    do_w(16, 4'hF, 15, fw, lw);
    wait_b(2'b00, -1, "preload");
    do_ar(32'h0, 4'd15, 3'b010, 2'b01, hs);
    collect_r(16);
    check("rd16_first_lat", r_first, hs + 1);
    check("rd16_back2back", r_last - r_first, 32'd15);
    for (int i = 0; i < 16; i++) begin
      check($sformatf("rd16_data%0d", i), rbuf[i], 32'(i));
      check($sformatf("rd16_rlast%0d", i), 32'(rlast_buf[i]), (i == 15) ? 32'd1 : 32'd0);
      check($sformatf("rd16_rresp%0d", i), 32'(rresp_buf[i]), 32'd0);
    end
    @(negedge clk);
    check("rd16_arready_after", 32'(axi.arready), 32'd1);
    tick();

    // 4-beat write at 0x100, B latency and readback.
    for (int i = 0; i < 4; i++) wbuf[i] = 32'hA0 + 32'(i);
    do_aw(32'h100, 4'd3, 3'b010, 2'b01, hs);
    do_w(4, 4'hF, 3, fw, lw);
    check("wr4_wready_lat", fw, hs + 1);
    wait_b(2'b00, lw + 1 + Lat, "wr4");
    do_ar(32'h100, 4'd3, 3'b010, 2'b01, hs);
    collect_r(4);
    for (int i = 0; i < 4; i++) check($sformatf("wr4_data%0d", i), rbuf[i], 32'hA0 + 32'(i));

    // Five back-to-back writes with bready low; second one lacks wlast.
    for (int k = 0; k < 4; k++) begin
      wbuf[0] = 32'(k + 1);
      do_aw(32'h300 + 32'(4 * k), 4'd0, 3'b010, 2'b01, hs);
      do_w(1, 4'hF, (k == 1) ? -1 : 0, fw, lw);
    end
    @(negedge clk);
    check("pend4_awready", 32'(axi.awready), 32'd0);
    tick();
    axi.awaddr = 32'h310; axi.awlen = 4'd0; axi.awsize = 3'b010; axi.awburst = 2'b01;
    axi.awvalid = 1;
    repeat (8) tick();
    @(negedge clk);
    check("pend4_awready_held", 32'(axi.awready), 32'd0);
    check("pend4_bvalid_held", 32'(axi.bvalid), 32'd1);
    check("pend4_bresp0", 32'(axi.bresp), 32'd0);
    axi.bready = 1;
    tick();
    axi.bready = 0;
    @(negedge clk);
    check("pend4_awready_back", 32'(axi.awready), 32'd1);
    tick();
    axi.awvalid = 0;
    wbuf[0] = 32'd5;
    do_w(1, 4'hF, 0, fw, lw);
    wait_b(2'b10, -1, "order1");
    wait_b(2'b00, -1, "order2");
    wait_b(2'b00, -1, "order3");
    wait_b(2'b00, -1, "order4");
    do_ar(32'h300, 4'd4, 3'b010, 2'b01, hs);
    collect_r(5);
    for (int i = 0; i < 5; i++) check($sformatf("b2b_data%0d", i), rbuf[i], 32'(i + 1));

    // Illegal read size: data served, every beat SLVERR.
    do_ar(32'h0, 4'd3, 3'b001, 2'b01, hs);
    collect_r(4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("ilrd_rresp%0d", i), 32'(rresp_buf[i]), 32'd2);
      check($sformatf("ilrd_data%0d", i), rbuf[i], 32'(i));
    end

    // Early wlast: burst still runs 4 beats, B reports SLVERR.
    for (int i = 0; i < 4; i++) wbuf[i] = 32'hB0 + 32'(i);
    do_aw(32'h140, 4'd3, 3'b010, 2'b01, hs);
    do_w(4, 4'hF, 1, fw, lw);
    check("earlylast_beats", lw - fw, 32'd3);
    @(negedge clk);
    check("earlylast_wready_done", 32'(axi.wready), 32'd0);
    tick();
    wait_b(2'b10, -1, "earlylast");
    do_ar(32'h140, 4'd3, 3'b010, 2'b01, hs);
    collect_r(4);
    for (int i = 0; i < 4; i++) check($sformatf("earlylast_data%0d", i), rbuf[i], 32'hB0 + 32'(i));

    // Illegal burst type on write.
    wbuf[0] = 32'h7777_0000;
    do_aw(32'h150, 4'd0, 3'b010, 2'b00, hs);
    do_w(1, 4'hF, 0, fw, lw);
    wait_b(2'b10, -1, "fixedburst");

    // Reset mid-write and mid-read (read on beat 5).
    for (int i = 0; i < 3; i++) wbuf[i] = 32'hC0 + 32'(i);
    do_aw(32'h180, 4'd7, 3'b010, 2'b01, hs);
    do_w(3, 4'hF, -1, fw, lw);
    do_ar(32'h0, 4'd15, 3'b010, 2'b01, hs);
    collect_r(4);
    axi.rready = 1;
    @(negedge clk);
    check("rst_mid_rvalid_pre", 32'(axi.rvalid), 32'd1);
    check("rst_mid_beat5", axi.rdata, 32'd4);
    #2 rst_n = 0;
    #1;
    check("rst_mid_rvalid", 32'(axi.rvalid), 32'd0);
    check("rst_mid_wready", 32'(axi.wready), 32'd0);
    check("rst_mid_bvalid", 32'(axi.bvalid), 32'd0);
    tick();
    axi.rready = 0;
    rst_n = 1;
    @(negedge clk);
    check("rst_mid_arready", 32'(axi.arready), 32'd1);
    check("rst_mid_awready", 32'(axi.awready), 32'd1);
    nb = 0;
    axi.bready = 1;
    for (int i = 0; i < 8; i++) begin
      tick();
      @(negedge clk);
      if (axi.bvalid) nb++;
    end
    axi.bready = 0;
    check("rst_mid_no_b", nb, 32'd0);
    tick();
    do_ar(32'h180, 4'd2, 3'b010, 2'b01, hs);
    collect_r(3);
    for (int i = 0; i < 3; i++) check($sformatf("rst_mid_kept%0d", i), rbuf[i], 32'hC0 + 32'(i));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
